// File: rtl/tdec_wrap_crc12_chk_if.sv
// Block/beat handshake bundle for the CRC-12 block checker.
interface tdec_wrap_crc12_chk_if #(
    parameter int BLEN_W = 16
);
    logic              start;
    logic [BLEN_W-1:0] blk_bits;
    logic              din_vld;
    logic [7:0]        din;
    logic              din_rdy;
    logic              busy;
    logic              done;
    logic              crc_ok;
    logic [11:0]       crc_rem;

    modport master (
        output start, blk_bits, din_vld, din,
        input  din_rdy, busy, done, crc_ok, crc_rem
    );

    modport slave (
        input  start, blk_bits, din_vld, din,
        output din_rdy, busy, done, crc_ok, crc_rem
    );
endinterface

// File: rtl/tdec_wrap_crc12_chk.sv
// Sequential CRC-12 (0x80F) checker for decoded blocks: byte-wide update, bit-serial tail.
// Optional block/fail statistics counters enabled by TDEC_CRC12_CHK_STAT_EN.
module tdec_wrap_crc12_chk #(
    parameter int BLEN_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tdec_wrap_crc12_chk_if.slave  bus
`ifdef TDEC_CRC12_CHK_STAT_EN
    ,
    output logic [15:0]           blk_cnt,
    output logic [15:0]           fail_cnt
`endif
);
    localparam int CW = BLEN_W - 2;
    localparam int NW = BLEN_W - 3;

    typedef enum logic [1:0] {IDLE, BYTE, TAIL, DONE} state_t;

    state_t         state_q, state_d;
    logic [11:0]    crc_q, crc_d;
    logic [NW-1:0]  nbyte_q, nbyte_d;
    logic [2:0]     nrem_q, nrem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     sr_q, sr_d;
    logic [2:0]     tleft_q, tleft_d;
    logic           done_q, done_d;
    logic           ok_q, ok_d;
    logic [11:0]    rem_q, rem_d;

    logic           xfer;
    logic           illegal;
    logic           last_full;
    logic           part_beat;
    logic [CW-1:0]  full_cnt;
    logic [11:0]    crc_byte;
    logic [11:0]    crc_bit;
    logic [11:0]    tail_fin;

    function automatic logic [11:0] crc_step(input logic [11:0] c, input logic b);
        logic f;
        f = b ^ c[11];
        return {c[10:0], 1'b0} ^ (f ? 12'h80F : 12'h000);
    endfunction

    function automatic logic [11:0] crc8(input logic [11:0] c, input logic [7:0] d);
        logic [11:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            r = crc_step(r, d[i]);
        end
        return r;
    endfunction

    assign xfer      = bus.din_vld & (state_q == BYTE);
    assign illegal   = bus.blk_bits < BLEN_W'(13);
    assign full_cnt  = CW'(nbyte_q);
    assign last_full = (cnt_q + CW'(1)) == full_cnt;
    assign part_beat = cnt_q == full_cnt;
    assign crc_byte  = crc8(crc_q, bus.din);
    assign crc_bit   = crc_step(crc_q, sr_q[0]);
    assign tail_fin  = (tleft_q != 3'd0) ? crc_bit : crc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Illegal lengths pass through TAIL with zero steps so done lands one edge later.
    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = illegal ? TAIL : BYTE;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                BYTE: begin
                    if (xfer) begin
                        if (part_beat) begin
                            state_d = TAIL;
                        end else if (last_full && (nrem_q == 3'd0)) begin
                            state_d = DONE;
                        end
                    end
                end
                TAIL: begin
                    if (tleft_q <= 3'd1) begin
                        state_d = DONE;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        crc_d   = crc_q;
        nbyte_d = nbyte_q;
        nrem_d  = nrem_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        tleft_d = tleft_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        rem_d   = rem_q;
        if (bus.start) begin
            nbyte_d = bus.blk_bits[BLEN_W-1:3];
            nrem_d  = bus.blk_bits[2:0];
            cnt_d   = '0;
            tleft_d = '0;
            crc_d   = illegal ? '1 : '0;
        end else begin
            case (state_q)
                BYTE: begin
                    if (xfer) begin
                        if (part_beat) begin
                            sr_d    = bus.din;
                            tleft_d = nrem_q;
                        end else begin
                            crc_d = crc_byte;
                            cnt_d = cnt_q + CW'(1);
                            if (last_full && (nrem_q == 3'd0)) begin
                                done_d = 1'b1;
                                ok_d   = crc_byte == 12'h000;
                                rem_d  = crc_byte;
                            end
                        end
                    end
                end
                TAIL: begin
                    if (tleft_q != 3'd0) begin
                        crc_d   = crc_bit;
                        sr_d    = sr_q >> 1;
                        tleft_d = tleft_q - 3'd1;
                    end
                    if (tleft_q <= 3'd1) begin
                        done_d = 1'b1;
                        ok_d   = tail_fin == 12'h000;
                        rem_d  = tail_fin;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q   <= '0;
            nbyte_q <= '0;
            nrem_q  <= '0;
            cnt_q   <= '0;
            sr_q    <= '0;
            tleft_q <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            rem_q   <= '0;
        end else begin
            crc_q   <= crc_d;
            nbyte_q <= nbyte_d;
            nrem_q  <= nrem_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            tleft_q <= tleft_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        bus.din_rdy = state_q == BYTE;
        bus.busy    = state_q != IDLE;
        bus.done    = done_q;
        bus.crc_ok  = ok_q;
        bus.crc_rem = rem_q;
    end

`ifdef TDEC_CRC12_CHK_STAT_EN
    logic [15:0] blk_cnt_q;
    logic [15:0] fail_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q  <= '0;
            fail_cnt_q <= '0;
        end else if (done_q) begin
            if (blk_cnt_q != '1) begin
                blk_cnt_q <= blk_cnt_q + 16'd1;
            end
            if (!ok_q && (fail_cnt_q != '1)) begin
                fail_cnt_q <= fail_cnt_q + 16'd1;
            end
        end
    end

    assign blk_cnt  = blk_cnt_q;
    assign fail_cnt = fail_cnt_q;
`endif
endmodule

// File: doc/tdec_wrap_crc12_chk.md
# tdec_wrap_crc12_chk

Sequential CRC-12 checker for turbo-decoder output blocks in the decoder wrapper. It consumes a decoded hard-decision block byte by byte, including the appended 12 CRC bits, and computes the remainder with polynomial x^12+x^11+x^3+x^2+x+1 (0x80F), initial value 0. A trailing partial byte is processed bit-serially. Per block it reports pass/fail (remainder == 0) and the final remainder to the HARQ/control logic.

## Interface
- BLEN_W, 16, width of the block bit-length input.
- clk  input  1  block clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; latches blk_bits and begins a block.
- blk_bits  input  BLEN_W  total block bits, payload plus 12 CRC bits; sampled only with start.
- din_vld  input  1  data beat valid.
- din  input  8  data beat; bit 0 is earliest in time.
- din_rdy  output  1  checker accepts a beat; a transfer occurs when din_vld & din_rdy.
- busy  output  1  block in progress (state != IDLE).
- done  output  1  one-cycle pulse; result valid.
- crc_ok  output  1  final remainder == 0; holds until next start.
- crc_rem  output  12  final remainder; holds until next start.

## Operation
- States: IDLE, BYTE, TAIL, DONE.
- Latch nbyte = blk_bits >> 3 and nrem = blk_bits[2:0]; beats expected = nbyte + (nrem != 0).
- IDLE: din_rdy=0. On start:
  - blk_bits < 13: go to DONE with remainder forced to 0xFFF, so crc_ok=0.
  - Otherwise clear crc to 0 and go to BYTE.
- BYTE: din_rdy=1.
  - Each full-byte transfer: crc <= crc8(din, crc), the 8-bit parallel update equal to 8 serial steps with din[0] first. Serial step: f = b ^ crc[11]; crc <= {crc[10:0],0} ^ (f ? 0x80F : 0).
  - After the last full byte: nrem==0 goes to DONE.
  - nrem!=0: the next beat is the partial byte. Its bits [nrem-1:0] are used and upper bits are ignored. It loads a shift register, then go to TAIL.
- TAIL: din_rdy=0. One serial step per cycle, shifting the register LSB first, for exactly nrem cycles. Then go to DONE.
- DONE: transient, one cycle. Returns to IDLE.
- done, crc_ok and crc_rem are registered on the edge of the final CRC update.
- start while busy aborts the current block and restarts with the new blk_bits. No done is issued for the aborted block. crc_ok and crc_rem keep their previous values until the new block's done.
- din_vld outside BYTE is ignored; din is never consumed.
- A beat and start in the same cycle: start wins, and the beat is not consumed.
- Beat counter width: BLEN_W-2 bits; no wrap is possible within a legal block.

## Timing
- Reset values: din_rdy=0, busy=0, done=0, crc_ok=0, crc_rem=0x000; state IDLE.
- start at edge s: busy=1 and din_rdy=1 from the cycle after s.
- Full bytes only, last beat at edge k: done=1 in the cycle after k, and din_rdy=0 in that same cycle.
- Partial byte, last beat at edge k: din_rdy=0 after k; tail steps at edges k+1..k+nrem; done=1 in the cycle after edge k+nrem.
- Illegal length, start at edge s: done=1 in the cycle after s+1.
- busy falls in the cycle after done; a new start is legal in the done cycle.
- Throughput: one byte per cycle; no combinational path from din_vld to din_rdy.

## Configuration
- TDEC_CRC12_CHK_STAT_EN defined:
  - Adds output blk_cnt[15:0], counting completed blocks.
  - Adds output fail_cnt[15:0], counting done with crc_ok=0.
  - Both increment on done, saturate at 0xFFFF, and clear only on rst_n.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

## Test plan
- All-zero block, blk_bits=20 (2 bytes plus 4-bit tail), beats 0x00, 0x00, 0x00 back-to-back -> done 4 cycles after the third beat edge; crc_ok=1, crc_rem=0x000.
- Random 40-bit payload with model-computed CRC appended, blk_bits=52, din_vld toggling 1010 -> crc_ok=1; din_rdy never drops during BYTE.
- Same block with din[0] of the first beat flipped -> crc_ok=0; crc_rem equals the model remainder (nonzero).
- blk_bits=8 -> no beats accepted; done 2 cycles after start; crc_ok=0, crc_rem=0xFFF.
- start reasserted after 3 beats of a 64-bit block, then a full legal 24-bit block -> exactly one done; result matches the second block only.
- rst_n low during TAIL -> all outputs at reset values immediately; no done; the next block checks correctly.
- With TDEC_CRC12_CHK_STAT_EN: 3 good blocks and 2 bad blocks -> blk_cnt=5, fail_cnt=2.
